wallace_mul_arb: RTL and testbench
==================================

Name: wallace_mul_arb

Overview:
Two-requester round-robin arbiter and pipeline sequencer that shares one wallace_mul instance (16x16 unsigned, 32-bit product) between two independent clients. Each client has a valid/ready request channel and a valid/ready response channel. The block registers operands (stage S1), registers the product (stage S2) and routes each result back to the requester that issued it. It sits between client engines and the multiplier datapath and instantiates wallace_mul internally.

Parameters:
PRIO_INIT, 0, requester that holds priority after reset (0 or 1)
CNT_W, 16, width of per-requester completion counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset; also drives wallace_mul rst_n
req0_valid  input  1  requester 0 operands valid
req0_ready  output  1  requester 0 accepted this cycle when high with valid
req0_a  input  16  requester 0 multiplicand
req0_b  input  16  requester 0 multiplier
req1_valid  input  1  requester 1 operands valid
req1_ready  output  1  requester 1 ready
req1_a  input  16  requester 1 multiplicand
req1_b  input  16  requester 1 multiplier
rsp0_valid  output  1  product for requester 0 available
rsp0_ready  input  1  requester 0 consumes product
rsp0_q  output  32  product for requester 0
rsp1_valid  output  1  product for requester 1 available
rsp1_ready  input  1  requester 1 consumes product
rsp1_q  output  32  product for requester 1
busy  output  1  S1 or S2 holds a valid entry
done_cnt0  output  CNT_W  completed responses to requester 0, wraps
done_cnt1  output  CNT_W  completed responses to requester 1, wraps

Behaviour:
- State: S1 {s1_valid, s1_a, s1_b, s1_id}; S2 {s2_valid, s2_q, s2_id}; prio pointer (1 bit); two counters.
- Reset (async, rst_n low): s1_valid=0, s2_valid=0, data regs=0, prio=PRIO_INIT, done_cnt0/1=0. Outputs after reset: all ready=0 until next evaluation, then follow rules below; rsp*_valid=0, rsp*_q=0, busy=0. Any in-flight operation is discarded, with no response.
- rsp_fire = s2_valid && rspN_ready for N=s2_id.
- s2_free = !s2_valid || rsp_fire. S1->S2 move when s1_valid && s2_free: s2_q <= wallace_mul(s1_a, s1_b), s2_id <= s1_id, s2_valid <= 1. If S2 fires with no move, s2_valid <= 0.
- s1_free = !s1_valid || move. Winner: if only one reqN_valid, it wins. If both are valid, the prio requester wins. reqN_ready = s1_free && winner==N. The other requester's ready is 0.
- req_ready may depend combinationally on both req_valid and on rsp_ready. Requesters must not make valid depend on ready. Once asserted, valid and operands must hold until accepted.
- On accept: S1 loads operands and id, s1_valid <= 1, prio <= !winner. Prio does not change without an accept.
- rspN_valid = s2_valid && s2_id==N. rsp0_q = rsp1_q = s2_q.
- Latency: accept at edge k, response valid after edge k+1 (S1 at k, S2 at k+1), i.e. 2 cycles. Throughput is 1 op/cycle with no backpressure.
- Backpressure stalls the whole pipe (head-of-line): a held S2 blocks S1, which blocks accepts for both requesters. Responses are returned in acceptance order.
- Simultaneous S2 fire, S1 move and new accept in one cycle is legal (full-rate streaming).
- Arithmetic is unsigned and exact: q = a*b, and 32 bits never overflow. Counters increment on the respective rsp_fire and wrap modulo 2^CNT_W.
- busy = s1_valid || s2_valid.

Test Plan:
1. Reset, then req0 valid a=3 b=5, rsp0_ready=1 -> req0_ready=1 at cycle 0; rsp0_valid=1, rsp0_q=15 two cycles later for 1 cycle; done_cnt0=1; rsp1_valid never asserts.
2. Both requesters hold valid continuously (req0 a=2 b=7, req1 a=4 b=9), PRIO_INIT=0, responses always ready -> grants 0,1,0,1...; responses 14,36 alternate on rsp0/rsp1 at 1/cycle.
3. Extreme operands a=0xFFFF b=0xFFFF from req1 -> rsp1_q=0xFFFE0001; a=0 b=0xFFFF -> 0.
4. rsp0_ready=0 with a req0 result in S2 and a req1 op in S1 -> S2 holds, both req_ready=0, rsp1_valid=0, busy=1. Release rsp0_ready -> req0 result drains, then the req1 result follows in the next cycle, in order.
5. CNT_W=2, five req0 ops completed -> done_cnt0 sequence 1,2,3,0,1.
6. Assert rst_n low mid-stream with S1 and S2 full -> immediately rsp*_valid=0, busy=0, prio=PRIO_INIT. After release, no stale response appears and a new op returns the correct product.

Source files
------------

// File: rtl/wallace_mul_arb.sv
// Two-client round-robin front end sharing one registered 16x16 Wallace multiplier.
// Two-stage pipe (operands, then product); a stalled response holds the whole pipe.

module wallace_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [31:0] p_q;

  // Word-level carry-save reduction: every 3 rows become sum + shifted majority,
  // 16 rows collapse to 2 in six levels, then one final carry-propagate add.
  function automatic logic [31:0] wallace(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r [16];
    logic [31:0] t [16];
    int n;
    int m;
    int j;
    for (int i = 0; i < 16; i++) begin
      r[i] = b[i] ? ({16'b0, a} << i) : 32'b0;
    end
    n = 16;
    for (int lvl = 0; lvl < 6; lvl++) begin
      m = 0;
      for (int i = 0; i < 16; i++) t[i] = 32'b0;
      for (int g = 0; g < 5; g++) begin
        j = 3 * g;
        if (j + 2 < n) begin
          t[m[3:0]]       = r[j[3:0]] ^ r[j[3:0] + 4'd1] ^ r[j[3:0] + 4'd2];
          t[m[3:0] + 4'd1] = ((r[j[3:0]] & r[j[3:0] + 4'd1]) |
                              (r[j[3:0]] & r[j[3:0] + 4'd2]) |
                              (r[j[3:0] + 4'd1] & r[j[3:0] + 4'd2])) << 1;
          m = m + 2;
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (i >= n - (n % 3) && i < n) begin
          t[m[3:0]] = r[i];
          m = m + 1;
        end
      end
      r = t;
      n = m;
    end
    return r[0] + r[1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 32'b0;
    end else if (en_i) begin
      p_q <= wallace(a_i, b_i);
    end
  end

  assign p_o = p_q;

endmodule

module wallace_mul_arb #(
  parameter logic PRIO_INIT = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_q,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_q,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_a_q, s1_a_d;
  logic [15:0]      s1_b_q, s1_b_d;
  logic             s1_id_q, s1_id_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_id_q, s2_id_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [31:0]      s2_q;

  logic rsp_fire, move, s1_free, winner, accept;

  always_comb begin
    rsp_fire   = s2_valid_q && (s2_id_q ? rsp1_ready : rsp0_ready);
    move       = s1_valid_q && (!s2_valid_q || rsp_fire);
    s1_free    = !s1_valid_q || move;
    // A lone requester wins outright; the pointer only breaks ties.
    winner     = (req0_valid && req1_valid) ? prio_q : req1_valid;
    accept     = s1_free && (req0_valid || req1_valid);
    req0_ready = accept && !winner;
    req1_ready = accept && winner;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    prio_d     = prio_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    if (move) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
    end else if (rsp_fire) begin
      s2_valid_d = 1'b0;
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = winner ? req1_a : req0_a;
      s1_b_d     = winner ? req1_b : req0_b;
      s1_id_d    = winner;
      prio_d     = !winner;
    end
    if (rsp_fire && !s2_id_q) cnt0_d = cnt0_q + CNT_W'(1);
    if (rsp_fire &&  s2_id_q) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= 16'b0;
      s1_b_q     <= 16'b0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      prio_q     <= PRIO_INIT;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      prio_q     <= prio_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  wallace_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (move),
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .p_o   (s2_q)
  );

  assign rsp0_valid = s2_valid_q && !s2_id_q;
  assign rsp1_valid = s2_valid_q && s2_id_q;
  assign rsp0_q     = s2_q;
  assign rsp1_q     = s2_q;
  assign busy       = s1_valid_q || s2_valid_q;
  assign done_cnt0  = cnt0_q;
  assign done_cnt1  = cnt1_q;

endmodule

// File: tb/tb_wallace_mul_arb.sv
// Directed bench: vector table of single ops plus streaming, stall, counter-wrap and reset sequences.

module tb_wallace_mul_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_q, rsp1_q;
  logic [15:0] done_cnt0, done_cnt1;
  logic        w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_busy;
  logic [31:0] w_rsp0_q, w_rsp1_q;
  logic [1:0]  w_done_cnt0, w_done_cnt1;

  always #5 clk = ~clk;

  wallace_mul_arb #(.PRIO_INIT(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_q(rsp0_q),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_q(rsp1_q),
    .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  // Narrow-counter copy driven by the same stimulus, used for wrap checks.
  wallace_mul_arb #(.PRIO_INIT(1'b0), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_q(w_rsp0_q),
    .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_q(w_rsp1_q),
    .busy(w_busy), .done_cnt0(w_done_cnt0), .done_cnt1(w_done_cnt1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        id;
    logic [31:0] q;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
    end
    @(negedge clk);
    chk("vec_ready", {req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("vec_s1_busy", busy, 1);
    chk("vec_s1_norsp", {rsp1_valid, rsp0_valid}, 0);
    tick();
    @(negedge clk);
    chk("vec_rsp_valid", {rsp1_valid, rsp0_valid}, v.id ? 32'd2 : 32'd1);
    chk("vec_rsp_q", v.id ? rsp1_q : rsp0_q, v.q);
    tick();
    if (v.id) exp_cnt1++; else exp_cnt0++;
    @(negedge clk);
    chk("vec_after_norsp", {rsp1_valid, rsp0_valid}, 0);
    chk("vec_after_idle", busy, 0);
    chk("vec_cnt0", {16'b0, done_cnt0}, exp_cnt0);
    chk("vec_cnt1", {16'b0, done_cnt1}, exp_cnt1);
    tick();
  endtask

  initial begin
    vec_t vecs[9];
    int   wrap_seq[5];
    vecs[0] = '{a: 16'd3,     b: 16'd5,     id: 1'b0, q: 32'd15};
    vecs[1] = '{a: 16'd2,     b: 16'd7,     id: 1'b0, q: 32'd14};
    vecs[2] = '{a: 16'd4,     b: 16'd9,     id: 1'b1, q: 32'd36};
    vecs[3] = '{a: 16'hFFFF,  b: 16'hFFFF,  id: 1'b1, q: 32'hFFFE0001};
    vecs[4] = '{a: 16'd0,     b: 16'hFFFF,  id: 1'b1, q: 32'd0};
    vecs[5] = '{a: 16'hFFFF,  b: 16'd1,     id: 1'b0, q: 32'h0000FFFF};
    vecs[6] = '{a: 16'd1000,  b: 16'd1000,  id: 1'b1, q: 32'd1000000};
    vecs[7] = '{a: 16'd255,   b: 16'd255,   id: 1'b0, q: 32'd65025};
    vecs[8] = '{a: 16'd12345, b: 16'd100,   id: 1'b1, q: 32'd1234500};
    wrap_seq = '{1, 2, 3, 0, 1};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_q", rsp0_q, 0);
    chk("rst_cnt", {done_cnt1, done_cnt0}, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Both requesters saturated: grants alternate starting from requester 0.
    do_reset();
    req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd7;
    req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd9;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) chk("stream_grant", {req1_ready, req0_ready}, (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c >= 2) begin
        chk("stream_rsp_valid", {rsp1_valid, rsp0_valid}, (c % 2 == 0) ? 32'd1 : 32'd2);
        chk("stream_rsp_q", (c % 2 == 0) ? rsp0_q : rsp1_q, (c % 2 == 0) ? 32'd14 : 32'd36);
      end else begin
        chk("stream_fill_norsp", {rsp1_valid, rsp0_valid}, 0);
      end
      tick();
    end
    @(negedge clk);
    chk("stream_cnt0", {16'b0, done_cnt0}, 4);
    chk("stream_cnt1", {16'b0, done_cnt1}, 4);
    tick();

    // Head-of-line stall on requester 0's response.
    do_reset();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    @(negedge clk);
    chk("hol_acc0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd9;
    @(negedge clk);
    chk("hol_acc1", req1_ready, 1);
    tick();
    req0_valid = 1'b1; req0_a = 16'd6; req0_b = 16'd7;
    req1_valid = 1'b1; req1_a = 16'd8; req1_b = 16'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("hol_held_rsp0", rsp0_valid, 1);
      chk("hol_held_q", rsp0_q, 15);
      chk("hol_no_rsp1", rsp1_valid, 0);
      chk("hol_ready", {req1_ready, req0_ready}, 0);
      chk("hol_busy", busy, 1);
      tick();
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("hol_rel_ready", {req1_ready, req0_ready}, 1);
    chk("hol_rel_q", rsp0_q, 15);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("hol_order_rsp1", {rsp1_valid, rsp0_valid}, 2);
    chk("hol_order_q1", rsp1_q, 36);
    chk("hol_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("hol_next_rsp0", {rsp1_valid, rsp0_valid}, 1);
    chk("hol_next_q0", rsp0_q, 42);
    tick();
    @(negedge clk);
    chk("hol_next_rsp1", {rsp1_valid, rsp0_valid}, 2);
    chk("hol_next_q1", rsp1_q, 24);
    tick();
    @(negedge clk);
    chk("hol_drained", busy, 0);
    chk("hol_cnts", {done_cnt1, done_cnt0}, {16'd2, 16'd2});
    tick();

    // Narrow counter wraps modulo 4.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_vec('{a: 16'(i + 1), b: 16'd3, id: 1'b0, q: 32'(3 * (i + 1))});
      chk("wrap_cnt", {30'b0, w_done_cnt0}, wrap_seq[i]);
    end

    // Reset while both stages hold operations.
    do_reset();
    req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd7;
    req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd9;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("midrst_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd6;
    req1_valid = 1'b1; req1_a = 16'd3; req1_b = 16'd3;
    @(negedge clk);
    chk("midrst_prio", {req1_ready, req0_ready}, 1);
    chk("midrst_nostale", {rsp1_valid, rsp0_valid}, 0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("midrst_acc1", req1_ready, 1);
    chk("midrst_nostale2", {rsp1_valid, rsp0_valid}, 0);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("midrst_rsp0", {rsp1_valid, rsp0_valid}, 1);
    chk("midrst_q0", rsp0_q, 42);
    tick();
    @(negedge clk);
    chk("midrst_rsp1", {rsp1_valid, rsp0_valid}, 2);
    chk("midrst_q1", rsp1_q, 9);
    tick();
    @(negedge clk);
    chk("midrst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
